// File: rtl/proc10_control_fsm_if.sv
// Bus-side control bundle between the proc10 sequencer and its datapath:
// instruction/start inputs and all per-timestep register and ALU strobes.
interface proc10_control_fsm_if #(
    parameter int IW   = 10,
    parameter int NREG = 4
);
    logic            Execute;
    logic [IW-1:0]   INSTR;
    logic            IRin;
    logic [NREG-1:0] Rin;
    logic [NREG-1:0] Rout;
    logic            ENW;
    logic            Ain;
    logic            Gin;
    logic            Gout;
    logic [1:0]      ALUcont;
    logic            Busy;
    logic            Done;
    logic [1:0]      Tstep;

    modport master (
        input  Execute, INSTR,
        output IRin, Rin, Rout, ENW, Ain, Gin, Gout, ALUcont, Busy, Done, Tstep
    );

    modport slave (
        output Execute, INSTR,
        input  IRin, Rin, Rout, ENW, Ain, Gin, Gout, ALUcont, Busy, Done, Tstep
    );
endinterface

// File: rtl/proc10_control_fsm.sv
// Timestep sequencer for the 10-bit processor: latches an instruction in T0 and
// issues one-hot register/bus strobes for LOAD, COPY, ADD and SUB over T1..T3.
module proc10_control_fsm #(
    parameter int IW   = 10,
    parameter int NREG = 4
) (
    input  logic                  CLKb,
    input  logic                  Clrb,
    proc10_control_fsm_if.master  bus
);
    typedef enum logic [1:0] {T0 = 2'b00, T1 = 2'b01, T2 = 2'b10, T3 = 2'b11} state_e;

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_COPY = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;

    state_e          state_q, state_d;
    logic [IW-1:0]   ir_q, ir_d;

    logic            irin, enw, ain, gin, gout, busy, done;
    logic [NREG-1:0] rin, rout;
    logic [1:0]      alucont, tstep;

    logic [1:0]      rx, ry;
    logic [3:0]      op;
    logic            unused_rsvd;

    assign rx          = ir_q[9:8];
    assign ry          = ir_q[7:6];
    assign op          = ir_q[3:0];
    assign unused_rsvd = ^ir_q[5:4];

    function automatic logic [NREG-1:0] onehot(input logic [1:0] idx);
        return NREG'(1) << idx;
    endfunction

    always_ff @(negedge CLKb) begin
        if (!Clrb) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        irin    = 1'b0;
        rin     = '0;
        rout    = '0;
        enw     = 1'b0;
        ain     = 1'b0;
        gin     = 1'b0;
        gout    = 1'b0;
        alucont = 2'b00;
        done    = 1'b0;

        unique case (state_q)
            T0: begin
                irin = bus.Execute;
                if (bus.Execute) begin
                    state_d = T1;
                    ir_d    = bus.INSTR;
                end
            end
            T1: begin
                state_d = T0;
                case (op)
                    OP_LOAD: begin
                        enw  = 1'b1;
                        rin  = onehot(rx);
                        done = 1'b1;
                    end
                    OP_COPY: begin
                        rout = onehot(ry);
                        rin  = onehot(rx);
                        done = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout    = onehot(rx);
                        ain     = 1'b1;
                        state_d = T2;
                    end
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                rout    = onehot(ry);
                gin     = 1'b1;
                alucont = (op == OP_SUB) ? 2'b10 : 2'b01;
                state_d = T3;
            end
            T3: begin
                gout    = 1'b1;
                rin     = onehot(rx);
                done    = 1'b1;
                state_d = T0;
            end
        endcase

        tstep = state_q;

        // Reset silences every strobe combinationally, so an aborted sequence emits nothing.
        if (!Clrb) begin
            irin    = 1'b0;
            rin     = '0;
            rout    = '0;
            enw     = 1'b0;
            ain     = 1'b0;
            gin     = 1'b0;
            gout    = 1'b0;
            alucont = 2'b00;
            done    = 1'b0;
            tstep   = 2'b00;
        end

        busy = (tstep != 2'b00);
    end

    assign bus.IRin    = irin;
    assign bus.Rin     = rin;
    assign bus.Rout    = rout;
    assign bus.ENW     = enw;
    assign bus.Ain     = ain;
    assign bus.Gin     = gin;
    assign bus.Gout    = gout;
    assign bus.ALUcont = alucont;
    assign bus.Busy    = busy;
    assign bus.Done    = done;
    assign bus.Tstep   = tstep;
endmodule
